// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered ALU with valid/busy handshake, accumulator mode and
//               an optional multi-cycle shift-add multiplier. Eight operations
//               on WIDTH-bit operands produce a 2*WIDTH-bit result register
//               that drives the display decoders directly.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      operand width in bits (>= 2); result is 2*WIDTH bits
// Ports
//   Clock      in   1        rising-edge clock
//   Reset_b    in   1        asynchronous active-low reset
//   A          in   WIDTH    operand A
//   B          in   WIDTH    operand B
//   Function   in   3        operation select
//   UseAcc     in   1        replace B by ALUout[WIDTH-1:0] at acceptance
//   in_valid   in   1        request, accepted on a rising edge with busy==0
//   busy       out  1        multiply in progress, requests ignored
//   out_valid  out  1        one-cycle pulse when ALUout was written
//   ALUout     out  2*WIDTH  result register
// Configuration macro
//   ALU_SEQ_MUL_EN  defined: Function 110 is a WIDTH-cycle shift-add multiply
//                   undefined: Function 110 writes zero in one cycle, busy=0
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 Clock,
    input  logic                 Reset_b,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           Function,
    input  logic                 UseAcc,
    input  logic                 in_valid,
    output logic                 busy,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   ALUout
);

    localparam int RW = 2 * WIDTH;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SEXT = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_CAT  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_HOLD = 3'b111;

    logic [WIDTH-1:0] bop;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [RW-1:0]    single_result;
    logic [RW-1:0]    result_next;
    logic             write_result;

    // Accumulator mode reads the register value present before the edge,
    // so back-to-back requests chain on the previous result.
    assign bop  = UseAcc ? ALUout[WIDTH-1:0] : B;
    assign sum  = {1'b0, A} + {1'b0, bop};
    assign diff = {1'b0, A} - {1'b0, bop};

    always_comb begin
        single_result = '0;
        case (Function)
            OP_ADD:  single_result = {{(WIDTH-1){1'b0}}, sum};
            OP_SUB:  single_result = {{(WIDTH-1){diff[WIDTH]}}, diff};
            OP_SEXT: single_result = {{WIDTH{bop[WIDTH-1]}}, bop};
            OP_OR:   single_result = {{(RW-1){1'b0}}, |{A, bop}};
            OP_AND:  single_result = {{(RW-1){1'b0}}, &{A, bop}};
            OP_CAT:  single_result = {A, bop};
            OP_MUL:  single_result = '0;   // only reached when the multiplier is absent
            OP_HOLD: single_result = ALUout;
            default: single_result = '0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [RW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [RW-1:0]    prod;
    logic [CW-1:0]    count;
    logic [RW-1:0]    prod_step;
    logic             mul_load;
    logic             mul_step;

    assign busy      = (state == MUL);
    assign prod_step = prod + (mplier[0] ? mcand : '0);

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        mul_load     = 1'b0;
        mul_step     = 1'b0;
        write_result = 1'b0;
        result_next  = single_result;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (Function == OP_MUL) begin
                        mul_load   = 1'b1;
                        state_next = MUL;
                    end else begin
                        write_result = 1'b1;
                    end
                end
            end
            MUL: begin
                mul_step = 1'b1;
                // Final step: commit the completed product straight from the
                // adder so no partial product ever reaches ALUout.
                if (count == CW'(1)) begin
                    write_result = 1'b1;
                    result_next  = prod_step;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            count  <= '0;
        end else if (mul_load) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= bop;
            prod   <= '0;
            count  <= CW'(WIDTH);
        end else if (mul_step) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            prod   <= prod_step;
            count  <= count - CW'(1);
        end
    end
`else
    // Without the multiplier every request completes in one cycle.
    assign busy = 1'b0;

    always_comb begin
        write_result = in_valid;
        result_next  = single_result;
    end
`endif

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            ALUout    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= write_result;
            if (write_result) begin
                ALUout <= result_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (WIDTH=4). Expected results
//               come from a bench-side model and are queued on issue, then
//               popped and compared when out_valid is seen. Multiply checks
//               follow ALU_SEQ_MUL_EN as seen by this file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic       Clock;
    logic       Reset_b;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] Function;
    logic       UseAcc;
    logic       in_valid;
    logic       busy;
    logic       out_valid;
    logic [7:0] ALUout;

    int         n_cmp;
    int         n_bad;
    logic [7:0] exp_q[$];
    logic [7:0] acc_model;

    alu_seq #(.WIDTH(4)) dut (
        .Clock     (Clock),
        .Reset_b   (Reset_b),
        .A         (A),
        .B         (B),
        .Function  (Function),
        .UseAcc    (UseAcc),
        .in_valid  (in_valid),
        .busy      (busy),
        .out_valid (out_valid),
        .ALUout    (ALUout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [7:0] model(input logic [2:0] f, input logic [3:0] a,
                                         input logic [3:0] bop, input logic [7:0] cur);
        int r;
        case (f)
            3'd0: r = int'(a) + int'(bop);
            3'd1: r = int'(a) - int'(bop);
            3'd2: r = bop[3] ? (int'(bop) + 240) : int'(bop);
            3'd3: r = (a != 4'h0 || bop != 4'h0) ? 1 : 0;
            3'd4: r = (a == 4'hF && bop == 4'hF) ? 1 : 0;
            3'd5: r = int'(a) * 16 + int'(bop);
`ifdef ALU_SEQ_MUL_EN
            3'd6: r = int'(a) * int'(bop);
`else
            3'd6: r = 0;
`endif
            default: r = int'(cur);
        endcase
        return r[7:0];
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic send(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b,
                        input logic u);
        logic [3:0] bop;
        bop      = u ? acc_model[3:0] : b;
        Function = f;
        A        = a;
        B        = b;
        UseAcc   = u;
        in_valid = 1'b1;
        exp_q.push_back(model(f, a, bop, acc_model));
    endtask

    task automatic test_reset();
        Reset_b  = 1'b1;
        in_valid = 1'b0;
        A = '0; B = '0; Function = '0; UseAcc = 1'b0;
        #2 Reset_b = 1'b0;
        #1;
        n_cmp++;
        if (ALUout !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: ALUout=%h out_valid=%b busy=%b, want 00/0/0", ALUout, out_valid, busy);
        end
        step();
        step();
        @(negedge Clock);
        Reset_b = 1'b1;
        step();
        n_cmp++;
        if (ALUout !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: ALUout=%h out_valid=%b busy=%b, want 00/0/0", ALUout, out_valid, busy);
        end
        acc_model = 8'h00;
        exp_q.delete();
    endtask

    task automatic test_single_ops();
        logic [2:0] ft[8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0};
        logic [3:0] at[8] = '{4'hF, 4'h2, 4'h0, 4'h0, 4'hF, 4'h3, 4'h9, 4'h8};
        logic [3:0] bt[8] = '{4'h1, 4'h3, 4'hA, 4'h0, 4'hF, 4'hC, 4'h9, 4'h8};
        logic [7:0] rt[8] = '{8'h10, 8'hFF, 8'hFA, 8'h00, 8'h01, 8'h3C, 8'h3C, 8'h10};
        logic [7:0] e;
        for (int i = 0; i < 8; i++) begin
            send(ft[i], at[i], bt[i], 1'b0);
            step();
            in_valid = 1'b0;
            e = exp_q.pop_front();
            acc_model = e;
            n_cmp++;
            if (out_valid !== 1'b1 || ALUout !== e || ALUout !== rt[i]) begin
                n_bad++;
                $display("FAIL op%0d_f%0d: out_valid=%b ALUout=%h, want 1/%h", i, ft[i], out_valid, ALUout, rt[i]);
            end
            step();
            n_cmp++;
            if (out_valid !== 1'b0 || ALUout !== e) begin
                n_bad++;
                $display("FAIL op%0d_clear: out_valid=%b ALUout=%h, want 0/%h", i, out_valid, ALUout, e);
            end
        end
    endtask

    task automatic test_accum();
        logic [7:0] e;
        logic [7:0] want[2] = '{8'h07, 8'h09};
        send(3'd5, 4'h0, 4'h5, 1'b0);
        step();
        e = exp_q.pop_front();
        acc_model = e;
        n_cmp++;
        if (out_valid !== 1'b1 || ALUout !== 8'h05) begin
            n_bad++;
            $display("FAIL acc_seed: out_valid=%b ALUout=%h, want 1/05", out_valid, ALUout);
        end
        for (int i = 0; i < 2; i++) begin
            send(3'd0, 4'h2, 4'h0, 1'b1);
            step();
            e = exp_q.pop_front();
            acc_model = e;
            n_cmp++;
            if (out_valid !== 1'b1 || ALUout !== e || ALUout !== want[i]) begin
                n_bad++;
                $display("FAIL acc_step%0d: out_valid=%b ALUout=%h, want 1/%h", i, out_valid, ALUout, want[i]);
            end
        end
        in_valid = 1'b0;
        UseAcc   = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        logic [2:0] f;
        for (int i = 0; i < 10; i++) begin
            f = 3'($urandom_range(0, 7));
            if (f == 3'd6) f = 3'd7;
            send(f, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            step();
            e = exp_q.pop_front();
            acc_model = e;
            n_cmp++;
            if (out_valid !== 1'b1 || ALUout !== e) begin
                n_bad++;
                $display("FAIL b2b%0d_f%0d: out_valid=%b ALUout=%h, want 1/%h", i, f, out_valid, ALUout, e);
            end
        end
        in_valid = 1'b0;
        UseAcc   = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: out_valid=%b, want 0", out_valid);
        end
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic test_multiply();
        logic [7:0] prev;
        logic [7:0] e;
        int         cyc;
        prev = acc_model;
        send(3'd6, 4'hF, 4'hF, 1'b0);
        step();                              // edge k: multiply accepted
        send(3'd0, 4'h1, 4'h1, 1'b0);        // must wait until edge k+5
        cyc = 0;
        while (busy === 1'b1 && cyc < 12) begin
            n_cmp++;
            if (ALUout !== prev || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL mul_hold%0d: ALUout=%h out_valid=%b, want %h/0", cyc, ALUout, out_valid, prev);
            end
            cyc++;
            step();
        end
        n_cmp++;
        if (cyc != 4) begin
            n_bad++;
            $display("FAIL mul_busy_len: busy cycles=%0d, want 4", cyc);
        end
        e = exp_q.pop_front();
        acc_model = e;
        n_cmp++;
        if (out_valid !== 1'b1 || ALUout !== e || ALUout !== 8'hE1) begin
            n_bad++;
            $display("FAIL mul_result: out_valid=%b ALUout=%h, want 1/e1", out_valid, ALUout);
        end
        step();                              // edge k+5: held add accepted
        in_valid = 1'b0;
        e = exp_q.pop_front();
        acc_model = e;
        n_cmp++;
        if (out_valid !== 1'b1 || ALUout !== 8'h02 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mul_next_accept: out_valid=%b ALUout=%h busy=%b, want 1/02/0", out_valid, ALUout, busy);
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        logic [7:0] e;
        Function = 3'd6; A = 4'h7; B = 4'h3; UseAcc = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 Reset_b = 1'b0;
        #1;
        n_cmp++;
        if (ALUout !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mul_reset: ALUout=%h out_valid=%b busy=%b, want 00/0/0", ALUout, out_valid, busy);
        end
        acc_model = 8'h00;
        exp_q.delete();
        @(negedge Clock);
        Reset_b = 1'b1;
        step();
        send(3'd0, 4'h1, 4'h1, 1'b0);
        step();
        in_valid = 1'b0;
        e = exp_q.pop_front();
        acc_model = e;
        n_cmp++;
        if (out_valid !== 1'b1 || ALUout !== 8'h02 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_add: out_valid=%b ALUout=%h busy=%b, want 1/02/0", out_valid, ALUout, busy);
        end
        step();
    endtask
`else
    task automatic test_mul_disabled();
        logic [7:0] e;
        send(3'd5, 4'h5, 4'hA, 1'b0);
        step();
        e = exp_q.pop_front();
        acc_model = e;
        send(3'd6, 4'hF, 4'hF, 1'b0);
        step();
        in_valid = 1'b0;
        e = exp_q.pop_front();
        acc_model = e;
        n_cmp++;
        if (out_valid !== 1'b1 || ALUout !== 8'h00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mul_off: out_valid=%b ALUout=%h busy=%b, want 1/00/0", out_valid, ALUout, busy);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mul_off_idle: out_valid=%b busy=%b, want 0/0", out_valid, busy);
        end
    endtask
`endif

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        acc_model = 8'h00;
        test_reset();
        test_single_ops();
        test_accum();
        test_back_to_back();
`ifdef ALU_SEQ_MUL_EN
        test_multiply();
        test_reset_mid_mul();
`else
        test_mul_disabled();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
